spi_byte_master: RTL and testbench

Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex. It converts a valid/ready byte request from the system side into one chip-select-framed 8-bit SPI transaction. It returns the byte shifted in on MISO with a one-cycle valid strobe. It sits between a system-clock-domain controller and one external SPI slave.

---
 rtl/spi_master_pkg.sv | 20 ++
 rtl/spi_byte_master_if.sv | 27 ++
 rtl/spi_sck_tick.sv | 29 ++
 rtl/spi_byte_master.sv | 109 ++++++++++
 tb/tb_spi_byte_master.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the single-byte SPI master.
// HALF is the SCK half-period in system clocks, never below one cycle.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  localparam int BIT_CNT_W = 3;

  function automatic int calc_half(input int sys_freq, input int sck_freq);
    int h;
    h = sys_freq / (2 * sck_freq);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// System-side byte request/response bundle of the SPI master.
// The controller takes the master modport; the SPI block takes the slave modport.
interface spi_byte_master_if;

  logic [7:0] tx_byte_i;
  logic       tx_byte_valid_i;
  logic       ready_o;
  logic [7:0] rx_byte_o;
  logic       rx_byte_valid_o;

  modport master (
    output tx_byte_i,
    output tx_byte_valid_i,
    input  ready_o,
    input  rx_byte_o,
    input  rx_byte_valid_o
  );

  modport slave (
    input  tx_byte_i,
    input  tx_byte_valid_i,
    output ready_o,
    output rx_byte_o,
    output rx_byte_valid_o
  );

endinterface

// File: rtl/spi_sck_tick.sv
// Half-period timer: one-cycle tick every HALF clocks while enabled.
// Dropping the enable restarts the count, so each phase starts cleanly.
module spi_sck_tick #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first, full-duplex single-byte SPI master.
// Every output comes straight from a register updated by the FSM below.
module spi_byte_master
  import spi_master_pkg::*;
#(
  parameter int SYS_FREQ = 100_000_000,
  parameter int SCK_FREQ = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miso_i,
  output logic                mosi_o,
  output logic                sck_o,
  output logic                cs_n_o,
  spi_byte_master_if.slave    bus
);

  localparam int HALF = calc_half(SYS_FREQ, SCK_FREQ);

  spi_state_t           state;
  logic [6:0]           tx_rest;
  logic [7:0]           rx_shift;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 ready_q;
  logic [7:0]           rx_byte_q;
  logic                 rx_valid_q;
  logic                 tick;

  spi_sck_tick #(
    .HALF (HALF)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // bit_cnt names the bit whose SCK pulse is in flight; the low phase after
  // bit 7 still runs its full length before the chip-select hold begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_rest    <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      sck_o      <= 1'b0;
      cs_n_o     <= 1'b1;
      mosi_o     <= 1'b0;
      ready_q    <= 1'b1;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_byte_valid_i) begin
            tx_rest  <= bus.tx_byte_i[6:0];
            rx_shift <= '0;
            bit_cnt  <= '0;
            cs_n_o   <= 1'b0;
            mosi_o   <= bus.tx_byte_i[7];
            ready_q  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sck_o    <= 1'b1;
            rx_shift <= {rx_shift[6:0], miso_i};
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sck_o) begin
              sck_o <= 1'b0;
              if (bit_cnt != BIT_CNT_W'(7)) begin
                mosi_o  <= tx_rest[6];
                tx_rest <= {tx_rest[5:0], 1'b0};
              end
            end else if (bit_cnt == BIT_CNT_W'(7)) begin
              state <= HOLD;
            end else begin
              sck_o    <= 1'b1;
              rx_shift <= {rx_shift[6:0], miso_i};
              bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_o     <= 1'b1;
            ready_q    <= 1'b1;
            mosi_o     <= 1'b0;
            rx_byte_q  <= rx_shift;
            rx_valid_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o         = ready_q;
  assign bus.rx_byte_o       = rx_byte_q;
  assign bus.rx_byte_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: expected bytes are queued at request
// time and popped by a negedge monitor when the receive strobe appears.
module tb_spi_byte_master;

  localparam int HALF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic miso_i;
  logic mosi_o;
  logic sck_o;
  logic cs_n_o;
  logic loopback = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sh = 8'h00;

  spi_byte_master_if bus ();

  spi_byte_master #(
    .SYS_FREQ (100_000_000),
    .SCK_FREQ (25_000_000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .miso_i (miso_i),
    .mosi_o (mosi_o),
    .sck_o  (sck_o),
    .cs_n_o (cs_n_o),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: first bit is presented when chip select falls, next bit on each SCK fall.
  always @(negedge cs_n_o) slave_sh = slave_byte;
  always @(negedge sck_o) slave_sh = {slave_sh[6:0], 1'b0};
  assign miso_i = loopback ? mosi_o : slave_sh[7];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_accept = 0;
  int rises = 0;
  int falls = 0;
  int sck_run = 0;
  int valid_run = 0;
  int valid_count = 0;
  logic prev_sck = 1'b0;
  logic prev_cs = 1'b1;
  logic [7:0] mon_mosi = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: frames each transfer on the chip-select fall, checks SCK phase
  // lengths and latencies, and settles scoreboard entries on the strobe.
  always @(negedge clk) begin
    logic [7:0] exp_rx;
    logic [7:0] exp_tx;
    cyc++;
    if (rst_n) begin
      if (prev_cs && !cs_n_o) begin
        rises    = 0;
        falls    = 0;
        mon_mosi = 8'h00;
      end
      if (sck_o != prev_sck) begin
        if (sck_o) begin
          if (rises == 0) checkOutput("first_rise_lat", cyc - last_accept, 1 + HALF);
          else            checkOutput("sck_low_len", sck_run, HALF);
          rises++;
          mon_mosi = {mon_mosi[6:0], mosi_o};
        end else begin
          checkOutput("sck_high_len", sck_run, HALF);
          falls++;
        end
        sck_run = 1;
      end else begin
        sck_run++;
      end
      if (bus.rx_byte_valid_o) begin
        valid_run++;
        valid_count++;
        if (valid_run == 1) begin
          checkOutput("rx_pending", rx_q.size() != 0, 1);
          if (rx_q.size() != 0) begin
            exp_rx = rx_q.pop_front();
            exp_tx = tx_q.pop_front();
            checkOutput("rx_byte", bus.rx_byte_o, exp_rx);
            checkOutput("mosi_bits", mon_mosi, exp_tx);
            checkOutput("sck_rises", rises, 8);
            checkOutput("sck_falls", falls, 8);
            checkOutput("done_lat", cyc - last_accept, 1 + 18 * HALF);
            checkOutput("cs_hi_done", cs_n_o, 1);
            checkOutput("ready_done", bus.ready_o, 1);
          end
        end
      end else begin
        if (valid_run != 0) checkOutput("valid_width", valid_run, 1);
        valid_run = 0;
      end
    end else begin
      valid_run = 0;
    end
    prev_sck = sck_o;
    prev_cs  = cs_n_o;
  end

  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] exp_rx,
                               input bit hold, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_req", bus.ready_o, 1);
    bus.tx_byte_i       = tx;
    bus.tx_byte_valid_i = 1'b1;
    if (track) begin
      rx_q.push_back(exp_rx);
      tx_q.push_back(tx);
    end
    @(posedge clk);
    last_accept = cyc;
    @(negedge clk);
    if (!hold) bus.tx_byte_valid_i = 1'b0;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_timeout", bus.ready_o, 1);
  endtask

  task automatic waitCycle(input int offset);
    int n;
    n = 0;
    while (cyc < last_accept + offset && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    bus.tx_byte_i       = 8'h00;
    bus.tx_byte_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_sck", sck_o, 0);
    checkOutput("rst_cs_n", cs_n_o, 1);
    checkOutput("rst_mosi", mosi_o, 0);
    checkOutput("rst_ready", bus.ready_o, 1);
    checkOutput("rst_rx_byte", bus.rx_byte_o, 8'h00);
    checkOutput("rst_rx_valid", bus.rx_byte_valid_o, 0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    loopback = 1'b1;
    applyStimulus(8'hA5, 8'hA5, 1'b0, 1'b1);
    waitReady();

    $display("[TB] slave model returning 3C");
    loopback   = 1'b0;
    slave_byte = 8'h3C;
    applyStimulus(8'hFF, 8'h3C, 1'b0, 1'b1);
    waitReady();

    $display("[TB] request while busy");
    loopback = 1'b1;
    applyStimulus(8'h81, 8'h81, 1'b0, 1'b1);
    waitCycle(10);
    bus.tx_byte_i       = 8'h00;
    bus.tx_byte_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_byte_valid_i = 1'b0;
    waitReady();
    repeat (5) @(negedge clk);
    checkOutput("idle_after_busy", cs_n_o, 1);

    $display("[TB] back-to-back 12/34");
    applyStimulus(8'h12, 8'h12, 1'b1, 1'b1);
    applyStimulus(8'h34, 8'h34, 1'b0, 1'b1);
    waitReady();

    $display("[TB] reset mid-transfer");
    applyStimulus(8'h5A, 8'h00, 1'b0, 1'b0);
    vc = valid_count;
    waitCycle(15);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", cs_n_o, 1);
    checkOutput("abort_sck", sck_o, 0);
    checkOutput("abort_mosi", mosi_o, 0);
    checkOutput("abort_ready", bus.ready_o, 1);
    checkOutput("abort_rx_byte", bus.rx_byte_o, 8'h00);
    checkOutput("abort_rx_valid", bus.rx_byte_valid_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("no_valid_after_abort", valid_count - vc, 0);
    checkOutput("ready_after_abort", bus.ready_o, 1);
    checkOutput("cs_idle_after_abort", cs_n_o, 1);
    checkOutput("rx_drained", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
